// File: rtl/puf_pkg.sv
// Shared types and default parameters for the PUF response voter.
package puf_pkg;

    localparam int N_BITS_DEF  = 8;
    localparam int N_EVAL_DEF  = 5;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } puf_state_e;

    // Counter width able to hold the value n (0..n inclusive).
    function automatic int vote_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_vote_cnt.sv
// One bit's vote tally across repeated evaluations, with majority and unanimity decode.
module puf_vote_cnt
    import puf_pkg::*;
#(
    parameter int N_EVAL = N_EVAL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic vote,
    output logic majority,
    output logic unstable
);

    localparam int CW = vote_width(N_EVAL);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && vote) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign majority = (cnt > CW'(N_EVAL / 2));
    assign unstable = (cnt != '0) && (cnt != CW'(N_EVAL));

endmodule

// File: rtl/puf_resp_voter.sv
// Repeats a PUF evaluation N_EVAL times per challenge and majority-votes each response bit.
module puf_resp_voter
    import puf_pkg::*;
#(
    parameter int N_BITS  = N_BITS_DEF,
    parameter int N_EVAL  = N_EVAL_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] challenge_in,
    output logic [N_BITS-1:0] puf_challenge,
    output logic              puf_rst,
    input  logic [N_BITS-1:0] puf_resp,
    input  logic [N_BITS-1:0] puf_finish,
    output logic [N_BITS-1:0] resp_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [N_BITS-1:0] unstable_mask,
    output logic              timeout_err,
    output logic              busy,
    output puf_state_e        state_dbg
);

    localparam int EW = vote_width(N_EVAL);
    localparam int TW = vote_width(TIMEOUT);

    puf_state_e    state;
    logic [EW-1:0] eval_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          all_fin;
    logic          clr_votes;
    logic          accum;
    logic [N_BITS-1:0] maj_bits;
    logic [N_BITS-1:0] unst_bits;

    assign all_fin   = &puf_finish;
    assign clr_votes = (state == ST_IDLE) && start;
    assign accum     = (state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            eval_cnt      <= '0;
            tmo_cnt       <= '0;
            puf_challenge <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        puf_challenge <= challenge_in;
                        eval_cnt      <= '0;
                        timeout_err   <= 1'b0;
                        state         <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A finish seen on the last allowed cycle still counts as a good evaluation.
                    if (all_fin) begin
                        state <= ST_ACCUM;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_ACCUM: begin
                    eval_cnt <= eval_cnt + EW'(1);
                    if (eval_cnt == EW'(N_EVAL - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_ARM;
                    end
                end
                ST_DONE: begin
                    // Result handshake: the result transfers in the cycle where
                    // resp_valid and resp_ready are both high; resp_valid never drops before that.
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BITS; gi++) begin : g_vote
            puf_vote_cnt #(
                .N_EVAL (N_EVAL)
            ) u_vote (
                .clk      (clk),
                .rst      (rst),
                .clr      (clr_votes),
                .en       (accum),
                .vote     (puf_resp[gi]),
                .majority (maj_bits[gi]),
                .unstable (unst_bits[gi])
            );
        end
    endgenerate

    // Counters are frozen in DONE, so these decodes hold steady until the handshake.
    assign resp_out      = (state == ST_DONE && !timeout_err) ? maj_bits : '0;
    assign unstable_mask = (state == ST_DONE) ? (timeout_err ? '1 : unst_bits) : '0;
    assign resp_valid    = (state == ST_DONE);
    assign puf_rst       = (state == ST_ARM);
    assign busy          = (state != ST_IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_puf_resp_voter.sv
// Table-driven bench for puf_resp_voter with a behavioural PUF array and result scoreboard.
module tb_puf_resp_voter;
    import puf_pkg::*;

    localparam int NB = 8;
    localparam int NE = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NB-1:0] challenge_in;
    logic [NB-1:0] puf_challenge;
    logic          puf_rst;
    logic [NB-1:0] puf_resp;
    logic [NB-1:0] puf_finish;
    logic [NB-1:0] resp_out;
    logic          resp_valid;
    logic          resp_ready;
    logic [NB-1:0] unstable_mask;
    logic          timeout_err;
    logic          busy;
    puf_state_e    state_dbg;

    always #5 clk = ~clk;

    puf_resp_voter #(
        .N_BITS  (NB),
        .N_EVAL  (NE),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .challenge_in  (challenge_in),
        .puf_challenge (puf_challenge),
        .puf_rst       (puf_rst),
        .puf_resp      (puf_resp),
        .puf_finish    (puf_finish),
        .resp_out      (resp_out),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .unstable_mask (unstable_mask),
        .timeout_err   (timeout_err),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // PUF array model: cycle counter restarted by puf_rst, evaluation index counted per pulse.
    int          pcnt = 100;
    int          ev_idx = 0;
    logic [39:0] cur_pats = '0;
    int          cur_wait = 4;
    bit          stuck7 = 1'b0;

    always @(posedge clk) begin
        if (start && !busy && !rst) ev_idx <= 0;
        else if (puf_rst)           ev_idx <= ev_idx + 1;
        if (puf_rst)          pcnt <= 0;
        else if (pcnt < 1000) pcnt <= pcnt + 1;
    end

    assign puf_resp   = (ev_idx >= 1 && ev_idx <= NE) ? cur_pats[8*(NE-ev_idx) +: 8] : 8'h00;
    assign puf_finish = (pcnt >= cur_wait - 1) ? (stuck7 ? 8'h7F : 8'hFF) : 8'h00;

    logic [16:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  chal;
        int          wait_w;
        bit          stuck;
        logic [39:0] pats;
        int          ready_dly;
        bit          poke;
        int          rst_at;
        logic [7:0]  exp_resp;
        logic [7:0]  exp_mask;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] chal, input int wait_w, input bit stuck,
                                input logic [39:0] pats, input int ready_dly, input bit poke,
                                input int rst_at, input logic [7:0] er, input logic [7:0] em,
                                input bit eto, input int lat);
        vec_t v;
        v.chal = chal; v.wait_w = wait_w; v.stuck = stuck; v.pats = pats;
        v.ready_dly = ready_dly; v.poke = poke; v.rst_at = rst_at;
        v.exp_resp = er; v.exp_mask = em; v.exp_to = eto; v.exp_lat = lat;
        return v;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_puf_rst"}, 32'(puf_rst), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_resp_out"}, 32'(resp_out), 0);
        check({tag, "_unstable_mask"}, 32'(unstable_mask), 0);
        check({tag, "_puf_challenge"}, 32'(puf_challenge), 0);
    endtask

    // Called #1 after a rising edge with the DUT idle; start is driven in that same cycle.
    task automatic run_vec(input vec_t v);
        int          cyc;
        bit          got;
        bit          aborted;
        logic [16:0] exp;
        cur_pats = v.pats;
        cur_wait = v.wait_w;
        stuck7   = v.stuck;
        challenge_in = v.chal;
        start = 1'b1;
        exp_q.push_back({v.exp_resp, v.exp_mask, v.exp_to});
        @(posedge clk); #1;
        start = 1'b0;
        challenge_in = ~v.chal;
        cyc = 1;
        check("puf_rst_in_arm", 32'(puf_rst), 1);
        check("busy_after_start", 32'(busy), 1);
        check("challenge_latched", 32'(puf_challenge), 32'(v.chal));
        got = 1'b0;
        aborted = 1'b0;
        while (!got && !aborted && cyc < 400) begin
            if (v.rst_at != 0 && cyc == v.rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_zero_outputs("after_rst");
                rst = 1'b0;
                void'(exp_q.pop_front());
                aborted = 1'b1;
            end else if (resp_valid) begin
                got = 1'b1;
            end else begin
                start = (v.poke && cyc == 4);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (aborted) return;
        if (!got) begin
            check("resp_valid_within_bound", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        check("latency", 32'(cyc), 32'(v.exp_lat));
        check("challenge_held", 32'(puf_challenge), 32'(v.chal));
        check("busy_in_done", 32'(busy), 1);
        check("puf_rst_low_in_done", 32'(puf_rst), 0);
        resp_ready = 1'b0;
        for (int k = 0; k < v.ready_dly; k++) begin
            check("stable_while_stalled", 32'({resp_out, unstable_mask, timeout_err}), 32'(exp_q[0]));
            check("valid_while_stalled", 32'(resp_valid), 1);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        exp = exp_q.pop_front();
        check("result", 32'({resp_out, unstable_mask, timeout_err}), 32'(exp));
        check("valid_at_handshake", 32'(resp_valid), 1);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("valid_after_handshake", 32'(resp_valid), 0);
        check("busy_after_handshake", 32'(busy), 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = mk(8'hA5, 4,  1'b0, {5{8'h3C}},                              0,  1'b0, 0,  8'h3C, 8'h00, 1'b0, 31);
        vecs[1] = mk(8'h5A, 4,  1'b0, {8'h01, 8'h01, 8'h00, 8'h01, 8'h00},     2,  1'b0, 0,  8'h01, 8'h01, 1'b0, 31);
        vecs[2] = mk(8'hFF, 4,  1'b1, {5{8'h3C}},                              1,  1'b0, 0,  8'h00, 8'hFF, 1'b1, 18);
        vecs[3] = mk(8'h3C, 16, 1'b0, {8'h81, 8'h83, 8'h87, 8'h8F, 8'h9F},     0,  1'b0, 0,  8'h87, 8'h1E, 1'b0, 91);
        vecs[4] = mk(8'hC3, 1,  1'b0, {8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h55},     3,  1'b0, 0,  8'hAA, 8'hFF, 1'b0, 16);
        vecs[5] = mk(8'h96, 4,  1'b0, {5{8'h00}},                              10, 1'b1, 0,  8'h00, 8'h00, 1'b0, 31);
        vecs[6] = mk(8'h11, 4,  1'b0, {5{8'h3C}},                              0,  1'b0, 15, 8'h00, 8'h00, 1'b0, 0);
        vecs[7] = mk(8'h22, 4,  1'b0, {5{8'h3C}},                              0,  1'b0, 0,  8'h3C, 8'h00, 1'b0, 31);
        vecs[8] = mk(8'h7E, 15, 1'b0, {5{8'hFF}},                              0,  1'b0, 0,  8'hFF, 8'h00, 1'b0, 86);

        rst = 1'b1;
        start = 1'b0;
        resp_ready = 1'b0;
        challenge_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_without_start", 32'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/puf_resp_voter.md
PUF_RESP_VOTER -- requirements
Module: puf_resp_voter

Interface
REQ-001 SHALL have parameter N_BITS, default 8: response width, equal to the number of puf_bit instances.
REQ-002 SHALL have parameter N_EVAL, default 5: evaluations per challenge; odd, 1..15.
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for one evaluation.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request an evaluation of challenge_in; honoured only in IDLE.
REQ-007 SHALL have port challenge_in, input, N_BITS: challenge, sampled when start is accepted.
REQ-008 SHALL have port puf_challenge, output, N_BITS: latched challenge driven to the PUF array.
REQ-009 SHALL have port puf_rst, output, 1: active-high restart pulse to the PUF array.
REQ-010 SHALL have port puf_resp, input, N_BITS: per-bit raw response from the PUF array.
REQ-011 SHALL have port puf_finish, input, N_BITS: per-bit measurement-complete flags.
REQ-012 SHALL have port resp_out, output, N_BITS: majority-voted response.
REQ-013 SHALL have port resp_valid, output, 1: resp_out, unstable_mask and timeout_err are valid.
REQ-014 SHALL have port resp_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port unstable_mask, output, N_BITS: bits whose votes were not unanimous.
REQ-016 SHALL have port timeout_err, output, 1: an evaluation did not finish within TIMEOUT cycles.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, ARM, WAIT, ACCUM and DONE.
REQ-019 IDLE with start=1 SHALL latch challenge_in into puf_challenge, clear the vote counters, eval_cnt and timeout_err, and go to ARM.
REQ-020 ARM SHALL last exactly one cycle with puf_rst=1, clear the timeout counter, and go to WAIT; puf_rst SHALL be 0 in all other states.
REQ-021 WAIT SHALL go to ACCUM on the first cycle in which all puf_finish bits are 1.
REQ-022 WAIT SHALL otherwise increment the timeout counter and, when the counter reaches TIMEOUT-1, set timeout_err and go to DONE.
REQ-023 When all-finish and timeout occur in the same cycle, finish SHALL take priority.
REQ-024 ACCUM SHALL take one cycle, add puf_resp[i] to vote_cnt[i] (width clog2(N_EVAL+1), no overflow possible) and increment eval_cnt.
REQ-025 ACCUM SHALL then go to DONE if eval_cnt was N_EVAL-1, else to ARM.
REQ-026 In DONE: resp_out[i] SHALL be (vote_cnt[i] > N_EVAL/2); unstable_mask[i] SHALL be (vote_cnt[i] != 0 and vote_cnt[i] != N_EVAL).
REQ-027 On timeout, resp_out SHALL be 0 and unstable_mask SHALL be all-ones.
REQ-028 In DONE, resp_valid SHALL be 1, and result outputs SHALL stay stable until the handshake.
REQ-029 The cycle with resp_valid=1 and resp_ready=1 SHALL transfer the result and return to IDLE.
REQ-030 Outside DONE, resp_valid SHALL be 0.
REQ-031 puf_challenge SHALL hold its value from acceptance until the next accepted start.
REQ-032 start in any non-IDLE state SHALL be ignored, with no queueing.
REQ-033 Minimum latency from start to resp_valid SHALL be 1 + N_EVAL*(1+W+1) cycles, where W is the wait cycles per evaluation (W>=1).

Reset
REQ-034 rst=1 SHALL force IDLE, puf_rst=0, resp_valid=0, busy=0, timeout_err=0, and resp_out, unstable_mask, puf_challenge, all counters = 0.
REQ-035 Reset asserted mid-operation SHALL abandon the evaluation, produce no result, and allow start to be accepted on the first cycle after rst deasserts.

Structure
REQ-036 The FSM state enum and the defaults for N_BITS, N_EVAL and TIMEOUT SHALL live in shared package puf_pkg.
REQ-037 The per-bit vote counter with its majority/unanimity decode SHALL be sub-module puf_vote_cnt, instantiated N_BITS times via generate.

Verification
REQ-038 Bench SHALL cover: start with challenge_in=8'hA5; PUF model returns 8'h3C with finish after 4 cycles, 5 times -> resp_out=8'h3C, unstable_mask=8'h00, timeout_err=0, resp_valid at cycle 1+5*6=31.
REQ-039 Bench SHALL cover: bit0 returns 1,1,0,1,0 and other bits steady 0 -> resp_out=8'h01, unstable_mask=8'h01.
REQ-040 Bench SHALL cover: puf_finish[7] never asserts -> timeout_err=1, resp_out=8'h00, unstable_mask=8'hFF, busy low after the handshake.
REQ-041 Bench SHALL cover: resp_ready held 0 for 10 cycles in DONE -> outputs stable, then one-cycle handshake returns to IDLE; a start issued during WAIT is ignored.
REQ-042 Bench SHALL cover: rst pulsed during the third evaluation -> all outputs 0 next cycle; a new start the following cycle completes normally.
REQ-043 Bench SHALL cover: all-finish on the same cycle the timeout counter hits TIMEOUT-1 -> ACCUM taken, timeout_err=0.
